// File: rtl/fp8_e4m3_unpack_stream.sv
// fp8_e4m3_unpack_stream
// Streaming FP8 E4M3 -> fixed-point decoder. Takes one packed word of up to
// LANES FP8 values per input handshake and emits them lane 0 first, one per
// cycle, as 20-bit two's-complement integers scaled by 2^9, each with a NaN
// flag and a last-lane marker.
//
// Optional build macro: FP8_UNPACK_NAN_CNT_EN adds a saturating 16-bit count
// of NaN lanes handed downstream (nan_count) and a synchronous clear
// (nan_count_clr). Without the macro neither port nor the counter exists.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid & ready are both high.
//   A producer holding valid keeps its payload stable until the transfer.
//   in_ready  = (state == IDLE) | (out_valid & out_last & out_ready), so a new
//               word can be taken on the same edge the previous word's last
//               lane leaves (no bubble); in_ready is combinational from
//               out_ready.
//   out_valid is registered; out_data/out_nan/out_last hold while
//               out_valid & !out_ready.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = EMIT).

module fp8_e4m3_unpack_stream #(
    parameter int LANES = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [CNT_W-1:0]     in_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [19:0]          out_data,
    output logic                 out_nan,
    output logic                 out_last,
    output logic                 dbg_state
`ifdef FP8_UNPACK_NAN_CNT_EN
    ,
    input  logic                 nan_count_clr,
    output logic [15:0]          nan_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t               state;
    logic [8*LANES-1:0]   word_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     lane_idx;

    logic [CNT_W-1:0]     eff_count;
    logic [CNT_W-1:0]     next_idx;
    logic [7:0]           next_byte;
    logic [20:0]          lane0_dec;
    logic [20:0]          next_dec;
    logic                 in_accept;
    logic                 out_fire;
    logic                 load_new;

    // Decode one E4M3 byte into {nan, value * 2^9 as 20-bit two's complement}.
    // Normal: {1,M} << (E-1); subnormal: M; NaN (S.1111.111) gives value 0.
    // Negative zero negates to zero naturally.
    function automatic logic [20:0] decode_fp8(input logic [7:0] b);
        logic [19:0] mag;
        logic [3:0]  e;
        e = b[6:3];
        if (b[6:0] == 7'h7F) begin
            return {1'b1, 20'd0};
        end
        if (e == 4'd0) begin
            mag = {17'd0, b[2:0]};
        end else begin
            mag = {16'd0, 1'b1, b[2:0]} << (e - 4'd1);
        end
        return {1'b0, (b[7] ? (~mag + 20'd1) : mag)};
    endfunction

    assign in_ready  = (state == IDLE) | (out_valid & out_last & out_ready);
    assign in_accept = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign dbg_state = (state == EMIT);

    // Clamp the lane count to LANES; a zero count is consumed without output.
    always_comb begin
        eff_count = in_count;
        if (in_count > CNT_W'(LANES)) begin
            eff_count = CNT_W'(LANES);
        end
    end

    assign load_new = in_accept & (eff_count != '0);

    // Select and decode the lane that follows the one currently presented,
    // plus lane 0 of the incoming word for the capture edge.
    always_comb begin
        next_idx  = lane_idx + CNT_W'(1);
        next_byte = 8'd0;
        for (int k = 0; k < LANES; k++) begin
            if (next_idx == CNT_W'(k)) begin
                next_byte = word_q[8*k +: 8];
            end
        end
        next_dec  = decode_fp8(next_byte);
        lane0_dec = decode_fp8(in_data[7:0]);
    end

    // Main FSM: capture words, step through lanes on output handshakes, and
    // chain straight into the next word when it arrives on the last handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_q    <= '0;
            count_q   <= '0;
            lane_idx  <= '0;
            out_valid <= 1'b0;
            out_data  <= 20'd0;
            out_nan   <= 1'b0;
            out_last  <= 1'b0;
        end else if (load_new) begin
            // Only reachable from IDLE or on the last-lane handshake in EMIT.
            state     <= EMIT;
            word_q    <= in_data;
            count_q   <= eff_count;
            lane_idx  <= '0;
            out_valid <= 1'b1;
            out_nan   <= lane0_dec[20];
            out_data  <= lane0_dec[19:0];
            out_last  <= (eff_count == CNT_W'(1));
        end else begin
            case (state)
                IDLE: begin
                    // Zero-count words are consumed here without leaving IDLE.
                    out_valid <= 1'b0;
                end
                EMIT: begin
                    if (out_fire) begin
                        if (out_last) begin
                            state     <= IDLE;
                            lane_idx  <= '0;
                            out_valid <= 1'b0;
                            out_data  <= 20'd0;
                            out_nan   <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            lane_idx <= next_idx;
                            out_nan  <= next_dec[20];
                            out_data <= next_dec[19:0];
                            out_last <= (next_idx == (count_q - CNT_W'(1)));
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FP8_UNPACK_NAN_CNT_EN
    // Saturating count of NaN lanes delivered downstream; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_count <= 16'd0;
        end else if (nan_count_clr) begin
            nan_count <= 16'd0;
        end else if (out_fire && out_nan && (nan_count != 16'hFFFF)) begin
            nan_count <= nan_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp8_e4m3_unpack_stream.sv
// Bench for fp8_e4m3_unpack_stream: directed decode / NaN / backpressure /
// back-to-back / count-edge / async-reset scenarios followed by randomized
// words, all checked against an arithmetic E4M3 model and an expected queue.
module tb_fp8_e4m3_unpack_stream;

  localparam int LANES = 4;
  localparam int CNT_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [8*LANES-1:0] in_data = '0;
  logic [CNT_W-1:0]   in_count = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [19:0]        out_data;
  logic               out_nan;
  logic               out_last;
  logic               dbg_state;
`ifdef FP8_UNPACK_NAN_CNT_EN
  logic               nan_count_clr = 1'b0;
  logic [15:0]        nan_count;
`endif

  fp8_e4m3_unpack_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nan   (out_nan),
    .out_last  (out_last),
    .dbg_state (dbg_state)
`ifdef FP8_UNPACK_NAN_CNT_EN
    ,
    .nan_count_clr (nan_count_clr),
    .nan_count     (nan_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [21:0] exp_q[$];   // {last, nan, data}
  int hs_cyc[$];
  logic lastrdy_q[$];
  int cyc = 0;
  int n_out = 0;
  int model_nan = 0;
  int rdy_mode = 0;        // 0: always ready, 1: random, 2: manual

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the E4M3 definition, scaled by 2^9.
  function automatic int ref_value(input logic [7:0] b, output bit nan);
    int e;
    int m;
    int mag;
    e = int'(b[6:3]);
    m = int'(b[2:0]);
    nan = (e == 15) && (m == 7);
    if (nan) return 0;
    if (e == 0) mag = m;
    else mag = (8 + m) * (1 << (e - 1));
    return b[7] ? -mag : mag;
  endfunction

  task automatic push_expect(input logic [31:0] d, input int c);
    int n;
    int v;
    bit nan;
    logic [7:0] b;
    n = (c > LANES) ? LANES : c;
    for (int i = 0; i < n; i++) begin
      b = d[8*i +: 8];
      v = ref_value(b, nan);
      exp_q.push_back({(i == n - 1), nan, v[19:0]});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [31:0] d, input int c);
    bit accepted;
    accepted = 0;
    in_data = d;
    in_count = CNT_W'(c);
    in_valid = 1'b1;
    push_expect(d, c);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        break;
      end
    end
    check("accept_timeout", 32'(accepted), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  logic hold_prev = 1'b0;
  logic [19:0] prev_data;
  logic prev_nan;
  logic prev_last;

  always @(negedge clk) begin
    logic [21:0] e;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, prev_data);
        check("hold_nan", 32'(out_nan), 32'(prev_nan));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[19:0]);
          check("out_nan", 32'(out_nan), 32'(e[20]));
          check("out_last", 32'(out_last), 32'(e[21]));
          if (e[20] && model_nan < 65535) model_nan++;
        end
        n_out++;
        hs_cyc.push_back(cyc);
        if (out_last) lastrdy_q.push_back(in_ready);
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_nan = out_nan;
      prev_last = out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n0;
    logic [31:0] d;
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_nan", 32'(out_nan), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef FP8_UNPACK_NAN_CNT_EN
    check("rst_nan_count", nan_count, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Decode values
    rdy_mode = 0;
    n0 = n_out;
    send_word(32'h017EB838, 4);
    drain(50);
    check("decode_count", n_out - n0, 4);

    // NaN and zero
    send_word(32'h0080FF7F, 3);
    drain(50);
`ifdef FP8_UNPACK_NAN_CNT_EN
    check("nan_count_2", nan_count, 32'd2);
`endif

    // Backpressure on lane 1
    rdy_mode = 2;
    out_ready = 1'b1;
    n0 = n_out;
    send_word(32'h017EB838, 4);
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'h0FFE00);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain(50);
    check("bp_count", n_out - n0, 4);

    // Back-to-back words
    rdy_mode = 0;
    hs_cyc.delete();
    lastrdy_q.delete();
    send_word(32'h00003830, 2);
    send_word(32'h0000B801, 2);
    drain(50);
    check("b2b_outputs", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) check("b2b_no_bubble", hs_cyc[3] - hs_cyc[0], 3);
    if (lastrdy_q.size() > 0) check("b2b_in_ready_last", 32'(lastrdy_q[0]), 32'd1);

    // Count edge cases
    n0 = n_out;
    send_word(32'h38383838, 0);
    repeat (4) begin
      @(negedge clk);
      check("cnt0_no_valid", 32'(out_valid), 32'd0);
    end
    check("cnt0_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_word(32'h40302010, 7);
    drain(50);
    check("cnt7_count", n_out - n0, 4);

    // Asynchronous reset while lane 1 is presented
    send_word(32'h017EB838, 4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    model_nan = 0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("arst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized words with random backpressure
    rdy_mode = 1;
    repeat (40) begin
      for (int i = 0; i < LANES; i++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 5) == 0) b = {b[7], 7'h7F};
        d[8*i +: 8] = b;
      end
      send_word(d, $urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain(2000);

`ifdef FP8_UNPACK_NAN_CNT_EN
    check("nan_count_rand", nan_count, 32'(model_nan));
    nan_count_clr = 1'b1;
    @(posedge clk);
    #1 nan_count_clr = 1'b0;
    model_nan = 0;
    @(negedge clk);
    check("nan_count_clr", nan_count, 32'(model_nan));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
